bitwise_op_arbiter: RTL and testbench
=====================================

Name: bitwise_op_arbiter

Overview:
Shares one registered 8-bit bitwise logic unit (OR/AND/XOR/NOR) between NREQ requesters. A round-robin arbiter selects one request per cycle and computes the result into a one-deep output register. The result is returned with the winner's ID under a valid/ready handshake. The block sits between multiple client blocks and the shared gate-level datapath (or_8bit-class logic).

Parameters:
WIDTH, 8, operand/result width in bits
NREQ, 4, number of requesters, legal range 2..8
IDW, 3, width of y_id; must be at least clog2(NREQ)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester request; bit i belongs to requester i
op  input  2*NREQ  per-requester opcode, slice [2i+1:2i]: 00 OR, 01 AND, 10 XOR, 11 NOR
a  input  WIDTH*NREQ  operand A, slice [WIDTH*i +: WIDTH]
b  input  WIDTH*NREQ  operand B, same slicing
gnt  output  NREQ  one-hot accept strobe, combinational, valid in the cycle of acceptance
y  output  WIDTH  registered result
y_valid  output  1  result register holds unconsumed data
y_id  output  IDW  index of the requester that produced y
y_ready  input  1  downstream consumer accepts y this cycle

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset values: y=0, y_valid=0, y_id=0, round-robin pointer ptr=0 (requester 0 highest priority). gnt=0 whenever rst=1.
- can_accept = !y_valid || y_ready.
- Arbitration:
  - When can_accept and |req, the winner is the first requester with req set, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - gnt[winner]=1 in that cycle; all other gnt bits are 0.
  - gnt=0 when !can_accept or req==0.
- Capture: on the edge where gnt is nonzero:
  - y <= f(op_w, a_w, b_w)
  - y_id <= winner
  - y_valid <= 1
  - ptr <= winner+1, wrapping NREQ-1 -> 0
- Latency: exactly 1 cycle from the accept edge to y_valid with the result. Throughput is 1 result per cycle when y_ready is held high.
- Drain: y_valid && y_ready with no new accept -> y_valid <= 0. y and y_id hold their last values.
- Simultaneous drain and accept in one cycle: the new result replaces the old one and y_valid stays 1. No bubble.
- Backpressure: y_valid && !y_ready -> y, y_id and y_valid are frozen, gnt=0 and ptr is unchanged.
- Requester contract:
  - Hold req, op, a and b stable until gnt[i] is seen at an edge.
  - Deassert req the cycle after gnt if there are no further operations.
  - Dropping req before it is granted is legal; the request is simply not served.
- Opcode arithmetic: all operations are pure bitwise on WIDTH bits with no carries. NOR = ~(a|b).
- Reset mid-operation: a pending result is discarded (y_valid=0) and ptr returns to 0. A requester granted in the reset cycle is NOT served, because gnt is forced to 0.
- Fairness: any continuously asserted request is granted within NREQ accepts.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - Adds output port xfer_count [15:0], counting completed output handshakes (y_valid && y_ready).
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Single OR: after reset, req=0001, op0=00, a0=8'b00011100, b0=8'b00010001, y_ready=1 -> gnt=0001 in the same cycle. Next cycle y=8'b00011101, y_valid=1, y_id=0.
2. All ops: requester 2 issues a=8'b10110010, b=8'b11110100 with op 00/01/10/11 on consecutive accepts -> y = 11110110, 10110000, 01000110, 00001001, all with y_id=2, back-to-back with no bubble.
3. Round-robin: req=1111 held, y_ready=1 -> grant order 0,1,2,3,0,1. Then req=1010 with ptr=2 -> order 3,1,3.
4. Backpressure: y_valid=1, y_ready=0 for 3 cycles with req=0100 -> gnt=0 and y/y_id stable. y_ready=1 -> drain and accept in the same cycle, next y_id=2.
5. Reset mid-stream: rst asserted while y_valid=1 and req=1111 -> next cycle y_valid=0, y=0, gnt=0 during rst. The first grant after rst deasserts goes to requester 0.
6. ARB_STATS_EN: 5 handshakes plus 2 stalled cycles -> xfer_count=5. Preload via 65536 handshakes -> xfer_count stays 16'hFFFF.

Source files
------------

// File: rtl/bitwise_op_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit OR/AND/XOR/NOR unit between NREQ requesters.
// Optional ARB_STATS_EN adds a saturating output-handshake counter (xfer_count).
module bitwise_op_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] a,
    input  logic [WIDTH*NREQ-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      y,
    output logic                  y_valid,
    output logic [IDW-1:0]        y_id,
    input  logic                  y_ready
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           xfer_count
`endif
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   winner;
    logic [NREQ-1:0]  win_oh;
    logic             found;
    logic             can_accept;
    logic             accept;
    logic [1:0]       op_w;
    logic [WIDTH-1:0] a_w, b_w, res;

    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [IDW-1:0]   y_id_q, y_id_d;

    assign can_accept = !y_valid_q || y_ready;

    // Two passes: requesters at or above ptr first, then the wrapped-around ones below it.
    always_comb begin
        found  = 1'b0;
        win_oh = '0;
        winner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr_q))) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
                winner    = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < 32'(ptr_q))) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
                winner    = IDW'(i);
            end
        end
    end

    assign accept = !rst && can_accept && found;
    assign gnt    = accept ? win_oh : '0;

    always_comb begin
        op_w = '0;
        a_w  = '0;
        b_w  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                op_w = op[2*i +: 2];
                a_w  = a[WIDTH*i +: WIDTH];
                b_w  = b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        unique case (op_w)
            2'b00:   res = a_w | b_w;
            2'b01:   res = a_w & b_w;
            2'b10:   res = a_w ^ b_w;
            2'b11:   res = ~(a_w | b_w);
            default: res = '0;
        endcase
    end

    always_comb begin
        y_d       = y_q;
        y_id_d    = y_id_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        if (accept) begin
            y_d       = res;
            y_id_d    = winner;
            y_valid_d = 1'b1;
            ptr_d     = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_id_q    <= '0;
            y_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_id_q    <= y_id_d;
            y_valid_q <= y_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_id    = y_id_q;
    assign y_valid = y_valid_q;

`ifdef ARB_STATS_EN
    logic [15:0] xfer_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else if (y_valid_q && y_ready && (xfer_count_q != 16'hFFFF)) begin
            xfer_count_q <= xfer_count_q + 16'd1;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Table-driven bench for bitwise_op_arbiter with a result scoreboard queue.
// Exercises the xfer_count checks only when ARB_STATS_EN is defined.
module tb_bitwise_op_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] a, b;
    logic [3:0]  gnt;
    logic [7:0]  y;
    logic        y_valid;
    logic [2:0]  y_id;
    logic        y_ready;
`ifdef ARB_STATS_EN
    logic [15:0] xfer_count;
`endif

    always #5 clk = ~clk;

    bitwise_op_arbiter #(
        .WIDTH(8),
        .NREQ (4),
        .IDW  (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op     (op),
        .a      (a),
        .b      (b),
        .gnt    (gnt),
        .y      (y),
        .y_valid(y_valid),
        .y_id   (y_id),
        .y_ready(y_ready)
`ifdef ARB_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rdy;
        logic [3:0]  egnt;
        logic        evalid;
        logic        chk_y;
        logic [7:0]  ey;
        logic        chk_rst;
    } vec_t;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] id;
    } res_t;

    vec_t vecs[$];
    res_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   hs     = 0;

    function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] x,
                                          input logic [7:0] z);
        case (o)
            2'b00:   return x | z;
            2'b01:   return x & z;
            2'b10:   return x ^ z;
            default: return ~(x | z);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] o,
                       input logic [31:0] av, input logic [31:0] bv, input logic rdy,
                       input logic [3:0] eg, input logic ev, input logic cy,
                       input logic [7:0] ey, input logic cr);
        vec_t v;
        v = '{rst: r, req: rq, op: o, a: av, b: bv, rdy: rdy, egnt: eg, evalid: ev,
              chk_y: cy, ey: ey, chk_rst: cr};
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int   w;
        res_t r;
        rst     = v.rst;
        req     = v.req;
        op      = v.op;
        a       = v.a;
        b       = v.b;
        y_ready = v.rdy;
        #2;
        chk("gnt", 32'(gnt), 32'(v.egnt));
        chk("y_valid", 32'(y_valid), 32'(v.evalid));
        if (v.chk_rst) begin
            chk("y_after_reset", 32'(y), 32'h0);
            chk("y_id_after_reset", 32'(y_id), 32'h0);
        end
        if (v.evalid && y_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                chk("y", 32'(y), 32'(sb[0].y));
                chk("y_id", 32'(y_id), 32'(sb[0].id));
                if (v.rdy && !v.rst) r = sb.pop_front();
            end
            if (v.chk_y) chk("y_const", 32'(y), 32'(v.ey));
        end
        if (v.egnt != 4'b0 && !v.rst) begin
            w = 0;
            for (int i = 0; i < 4; i++) if (v.egnt[i]) w = i;
            r.y  = ref_op(v.op[2*w +: 2], v.a[8*w +: 8], v.b[8*w +: 8]);
            r.id = 3'(w);
            sb.push_back(r);
        end
`ifdef ARB_STATS_EN
        chk("xfer_count", 32'(xfer_count), 32'(hs));
        if (v.rst) hs = 0;
        else if (v.evalid && v.rdy && hs < 16'hFFFF) hs++;
`endif
        @(posedge clk);
        #1;
        if (v.rst) sb.delete();
    endtask

    localparam logic [31:0] A3 = 32'h8C4A31F0;
    localparam logic [31:0] B3 = 32'h3C5A0F0F;
    localparam logic [7:0]  O3 = 8'b11_10_01_00;

    initial begin
        rst = 1'b1; req = '0; op = '0; a = '0; b = '0; y_ready = 1'b1;

        // Reset with requests pending: no grants.
        add(1, 4'b1111, O3, A3, B3, 1, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b1111, O3, A3, B3, 1, 4'b0000, 0, 0, 8'h00, 0);
        // Single OR from requester 0.
        add(0, 4'b0001, 8'h00, 32'h1C, 32'h11, 1, 4'b0001, 0, 0, 8'h00, 1);
        add(0, 4'b0000, 8'h00, 32'h0, 32'h0, 1, 4'b0000, 1, 1, 8'h1D, 0);
        add(0, 4'b0000, 8'h00, 32'h0, 32'h0, 1, 4'b0000, 0, 0, 8'h00, 0);
        // All four ops from requester 2, back to back.
        add(0, 4'b0100, 8'b00_00_00_00, 32'h00B20000, 32'h00F40000, 1, 4'b0100, 0, 0, 8'h00, 0);
        add(0, 4'b0100, 8'b00_01_00_00, 32'h00B20000, 32'h00F40000, 1, 4'b0100, 1, 1, 8'hF6, 0);
        add(0, 4'b0100, 8'b00_10_00_00, 32'h00B20000, 32'h00F40000, 1, 4'b0100, 1, 1, 8'hB0, 0);
        add(0, 4'b0100, 8'b00_11_00_00, 32'h00B20000, 32'h00F40000, 1, 4'b0100, 1, 1, 8'h46, 0);
        add(0, 4'b0000, 8'h00, 32'h0, 32'h0, 1, 4'b0000, 1, 1, 8'h09, 0);
        // Reset restores ptr=0, then round robin 0,1,2,3,0,1 and 3,1,3 with req=1010.
        add(1, 4'b0000, 8'h00, 32'h0, 32'h0, 1, 4'b0000, 0, 0, 8'h00, 0);
        add(0, 4'b1111, O3, A3, B3, 1, 4'b0001, 0, 0, 8'h00, 1);
        add(0, 4'b1111, O3, A3, B3, 1, 4'b0010, 1, 0, 8'h00, 0);
        add(0, 4'b1111, O3, A3, B3, 1, 4'b0100, 1, 0, 8'h00, 0);
        add(0, 4'b1111, O3, A3, B3, 1, 4'b1000, 1, 0, 8'h00, 0);
        add(0, 4'b1111, O3, A3, B3, 1, 4'b0001, 1, 0, 8'h00, 0);
        add(0, 4'b1111, O3, A3, B3, 1, 4'b0010, 1, 0, 8'h00, 0);
        add(0, 4'b1010, O3, A3, B3, 1, 4'b1000, 1, 0, 8'h00, 0);
        add(0, 4'b1010, O3, A3, B3, 1, 4'b0010, 1, 0, 8'h00, 0);
        add(0, 4'b1010, O3, A3, B3, 1, 4'b1000, 1, 0, 8'h00, 0);
        add(0, 4'b0000, O3, A3, B3, 1, 4'b0000, 1, 0, 8'h00, 0);
        add(0, 4'b0000, O3, A3, B3, 1, 4'b0000, 0, 0, 8'h00, 0);
        // Backpressure: three stalled cycles, then drain and accept together.
        add(0, 4'b0001, O3, A3, B3, 1, 4'b0001, 0, 0, 8'h00, 0);
        add(0, 4'b0100, O3, A3, B3, 0, 4'b0000, 1, 0, 8'h00, 0);
        add(0, 4'b0100, O3, A3, B3, 0, 4'b0000, 1, 0, 8'h00, 0);
        add(0, 4'b0100, O3, A3, B3, 0, 4'b0000, 1, 0, 8'h00, 0);
        add(0, 4'b0100, O3, A3, B3, 1, 4'b0100, 1, 0, 8'h00, 0);
        add(0, 4'b0000, O3, A3, B3, 1, 4'b0000, 1, 0, 8'h00, 0);
        add(0, 4'b0000, O3, A3, B3, 1, 4'b0000, 0, 0, 8'h00, 0);
        // Reset while a result is pending and all requesters are asking.
        add(0, 4'b1111, O3, A3, B3, 0, 4'b1000, 0, 0, 8'h00, 0);
        add(0, 4'b1111, O3, A3, B3, 0, 4'b0000, 1, 0, 8'h00, 0);
        add(1, 4'b1111, O3, A3, B3, 0, 4'b0000, 1, 0, 8'h00, 0);
        add(0, 4'b1111, O3, A3, B3, 1, 4'b0001, 0, 0, 8'h00, 1);
        add(0, 4'b0000, O3, A3, B3, 1, 4'b0000, 1, 0, 8'h00, 0);
        add(0, 4'b0000, O3, A3, B3, 1, 4'b0000, 0, 0, 8'h00, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

`ifdef ARB_STATS_EN
        // Saturation: stream well past 65535 handshakes.
        rst = 1'b0; req = 4'b0001; op = '0; a = A3; b = B3; y_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        chk("xfer_count_saturated", 32'(xfer_count), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("xfer_count_held", 32'(xfer_count), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
